uart_rx_deser: RTL and testbench

Serial receive front end of the UART datapath. Synchronises the asynchronous `rx` line, detects start bits using a 16× oversampling tick, samples eight data bits (LSB first) and one stop bit at bit centres, and presents the assembled byte with a single-cycle strobe. `data` and `data_valid` connect directly to the `data` and `en` inputs of the downstream 8-bit receive holding latch. `reset` is shared with that latch.

---
 rtl/uart_rx_deser.sv | 158 +++++++++++++++
 tb/tb_uart_rx_deser.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser.sv
// uart_rx_deser
//   Serial receive front end. Synchronises the asynchronous rx line, finds
//   start bits on a 16x (OVERSAMPLE) baud tick, samples eight data bits LSB
//   first plus one stop bit at bit centres, and presents the byte with a
//   single-cycle strobe that drives the downstream holding latch enable.
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   reset       asynchronous active-high reset (shared with the holding latch)
//   baud_tick   one-clk enable at OVERSAMPLE x baud rate
//   rx          asynchronous serial line, idles high
//   data        last correctly framed byte
//   data_valid  one-cycle strobe when data is updated
//   frame_err   one-cycle strobe when the stop bit is sampled low
//   busy        high whenever the receiver is not idle
module uart_rx_deser #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             armed_q, armed_d;
    logic             dv_q, dv_d;
    logic             fe_q, fe_d;
    logic             rx_meta_q, rx_s_q;

    // Two-flop synchroniser; resets to the idle (high) line level so a
    // reset release never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            armed_q <= 1'b0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            armed_q <= armed_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        armed_d = armed_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;

        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    // armed requires a high line first, so a line stuck low
                    // after reset or a break never starts a frame.
                    if (rx_s_q) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        cnt_d   = '0;
                        state_d = START;
                    end
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_d = '0;
                        if (!rx_s_q) begin
                            idx_d   = '0;
                            state_d = DATA;
                        end else begin
                            // Glitch shorter than half a bit: false start.
                            armed_d = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d   = '0;
                        shift_d = {rx_s_q, shift_q[7:1]};
                        idx_d   = idx_q + 1'b1;
                        if (idx_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        if (rx_s_q) begin
                            data_d  = shift_q;
                            dv_d    = 1'b1;
                            armed_d = 1'b1;
                        end else begin
                            // Low stop bit may be a break; re-arm only once
                            // the line has been seen high again.
                            fe_d    = 1'b1;
                            armed_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign data       = data_q;
    assign data_valid = dv_q;
    assign frame_err  = fe_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Testbench for uart_rx_deser. Stimulus tasks drive serial frames and push
// the expected strobe (kind, byte, clock index) into a queue computed from
// the frame timing rules; a negedge monitor pops and compares every strobe
// and checks that data holds between strobes.
module tb_uart_rx_deser;

    logic       clk;
    logic       reset;
    logic       baud_tick;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int cyc    = 0;
    int div    = 1;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_data = 8'h00;

    uart_rx_deser #(.OVERSAMPLE(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_tick  (baud_tick),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cyc equals the number of rising edges seen so far.
    initial begin
        forever begin
            @(posedge clk);
            cyc <= cyc + 1;
        end
    end

    // baud_tick is high during clock cycle n when n is a multiple of div,
    // so the tick is consumed on rising edge m when (m-1) % div == 0.
    initial begin
        baud_tick = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            baud_tick = ((cyc % div) == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n);
        repeat (n) tick_clk();
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick_clk();
    endtask

    // Edge index of the first baud tick at or after edge e.
    function automatic int first_tick(input int e);
        int m = e;
        while (((m - 1) % div) != 0) m++;
        return m;
    endfunction

    // Line falls now (after edge n); synchroniser makes it visible from edge
    // n+3, T0 is the first tick there, and the stop sample is 152 ticks later.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic push);
        int t0;
        t0 = first_tick(cyc + 3);
        if (push) exp_q.push_back('{err: !stop, data: b, cyc: t0 + 152 * div});
        rx = 1'b0;
        hold(16 * div);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(16 * div);
        end
        rx = stop;
        hold(16 * div);
    endtask

    // Scoreboard monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_data = 8'h00;
            end else if (data_valid || frame_err) begin
                chk("strobe_exclusive", 32'(data_valid && frame_err), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'(data_valid) + 32'(frame_err), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
                    chk("frame_err", 32'(frame_err), 32'(e.err));
                    chk("data_valid", 32'(data_valid), 32'(!e.err));
                    if (!e.err) exp_data = e.data;
                    chk("strobe_data", 32'(data), 32'(exp_data));
                end
            end else begin
                chk("data_hold", 32'(data), 32'(exp_data));
                if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                    chk("missed_strobe_cycle", 32'(cyc), 32'(exp_q[0].cyc));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int n;
        int t0;
        int gap;
        logic prev_err;
        logic [7:0] rb;
        logic rs;

        reset = 1'b1;
        rx    = 1'b1;

        // Reset and quiet line.
        hold(5);
        reset = 1'b0;
        #1;
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 200; i++) begin
            tick_clk();
            chk("idle_busy", 32'(busy), 32'd0);
        end

        // 0xA5 then 0x3C back-to-back, tick every clock.
        t0 = first_tick(cyc + 3);
        fork
            begin
                send_frame(8'hA5, 1'b1, 1'b1);
                send_frame(8'h3C, 1'b1, 1'b1);
            end
            begin
                wait_until(t0 - 1);
                chk("busy_before_T0", 32'(busy), 32'd0);
                wait_until(t0);
                chk("busy_after_T0", 32'(busy), 32'd1);
                wait_until(t0 + 151);
                chk("busy_at_T152", 32'(busy), 32'd1);
                wait_until(t0 + 152);
                chk("busy_after_T152", 32'(busy), 32'd0);
            end
        join
        hold(5);

        // Short glitch: false start at T8, then a good 0x5A.
        n  = cyc;
        t0 = first_tick(n + 3);
        rx = 1'b0;
        hold(4);
        rx = 1'b1;
        wait_until(t0 + 7);
        chk("glitch_busy_T7", 32'(busy), 32'd1);
        wait_until(t0 + 8);
        chk("glitch_busy_T8", 32'(busy), 32'd0);
        wait_until(n + 20);
        send_frame(8'h5A, 1'b1, 1'b1);
        hold(3);

        // 0xFF with low stop bit, then a long break.
        send_frame(8'hFF, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            tick_clk();
            if (i % 50 == 49) chk("break_busy", 32'(busy), 32'd0);
        end
        rx = 1'b1;
        hold(10);

        // Tick every 4th clock, 0x81, then reset mid-byte.
        div = 4;
        hold(8);
        send_frame(8'h81, 1'b1, 1'b1);
        hold(8);
        rx = 1'b0;
        hold(16 * 4 * 3);
        chk("midframe_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_data", 32'(data), 32'h00);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_valid", 32'(data_valid), 32'd0);
        chk("async_rst_ferr", 32'(frame_err), 32'd0);
        rx = 1'b1;
        hold(3);
        reset = 1'b0;
        hold(300);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Randomised frames, tick rate and gaps.
        prev_err = 1'b0;
        for (int k = 0; k < 8; k++) begin
            div = $urandom_range(1, 3);
            gap = $urandom_range(0, 12);
            if (prev_err) gap += 2 * div + 1;
            if (gap > 0) begin
                rx = 1'b1;
                hold(gap);
            end
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rb, rs, 1'b1);
            prev_err = !rs;
        end
        rx = 1'b1;
        hold(20);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
